// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and synchronizer depth for the SPI flash responder.
package spi_flash_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam logic [7:0] OP_READ        = 8'h03;
  localparam logic [7:0] OP_FAST_READ   = 8'h0B;
  localparam logic [7:0] OP_QUAD_READ   = 8'hEB;
  localparam logic [7:0] OP_READ_ID     = 8'h9F;
  localparam logic [7:0] OP_READ_STATUS = 8'h05;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_STATUS,
    ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    RD_SINGLE,
    RD_FAST,
    RD_QUAD
  } rd_kind_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings sck, cs_n and dq pads into the clk domain and flags sck/cs_n edges.
// Reset parks the chains in the bus-idle state (cs_n high, sck low).
module spi_pin_sync
  import spi_flash_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic [3:0] dq_i,
  output logic       cs_n_o,
  output logic       cs_fall_o,
  output logic       cs_rise_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic [3:0] dq_s_o
);

  logic [SYNC_DEPTH-1:0]      sck_q;
  logic [SYNC_DEPTH-1:0]      cs_q;
  logic [SYNC_DEPTH-1:0][3:0] dq_q;
  logic                       sck_prev_q;
  logic                       cs_prev_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sck_q      <= '0;
      cs_q       <= '1;
      dq_q       <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_q      <= {sck_q[SYNC_DEPTH-2:0], sck_i};
      cs_q       <= {cs_q[SYNC_DEPTH-2:0], cs_n_i};
      dq_q       <= {dq_q[SYNC_DEPTH-2:0], dq_i};
      sck_prev_q <= sck_q[SYNC_DEPTH-1];
      cs_prev_q  <= cs_q[SYNC_DEPTH-1];
    end
  end

  assign cs_n_o     = cs_q[SYNC_DEPTH-1];
  assign cs_fall_o  = cs_prev_q & ~cs_q[SYNC_DEPTH-1];
  assign cs_rise_o  = ~cs_prev_q & cs_q[SYNC_DEPTH-1];
  assign sck_rise_o = ~sck_prev_q & sck_q[SYNC_DEPTH-1];
  assign sck_fall_o = sck_prev_q & ~sck_q[SYNC_DEPTH-1];
  assign dq_s_o     = dq_q[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash target (read, fast read, quad I/O read, JEDEC ID, status) oversampled by clk.
// Data bytes come from a one-deep prefetch buffer refilled through the mem_req/mem_ack port.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter int          QUAD_DUMMY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic [3:0]  dq_i,
  output logic [3:0]  dq_o,
  output logic [3:0]  dq_oe,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        underrun
);

  localparam logic [4:0] QDUMMY_LAST = 5'(QUAD_DUMMY - 1);

  logic       cs_n_s, cs_fall, cs_rise, sck_rise, sck_fall;
  logic [3:0] dq_s;

  spi_pin_sync u_sync (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .sck_i      (sck),
    .cs_n_i     (cs_n),
    .dq_i       (dq_i),
    .cs_n_o     (cs_n_s),
    .cs_fall_o  (cs_fall),
    .cs_rise_o  (cs_rise),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .dq_s_o     (dq_s)
  );

  state_e      state_q, state_d;
  rd_kind_e    kind_q, kind_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [22:0] sh_in_q, sh_in_d;
  logic [7:0]  out_sh_q, out_sh_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic [3:0]  dq_o_q, dq_o_d, dq_oe_q, dq_oe_d;
  logic        cont_q, cont_d, underrun_q, underrun_d;
  logic        req_q, req_d, discard_q, discard_d, due_q, due_d;
  logic [23:0] maddr_q, maddr_d, due_addr_q, due_addr_d, nxt_addr_q, nxt_addr_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      kind_q     <= RD_SINGLE;
      cnt_q      <= '0;
      sh_in_q    <= '0;
      out_sh_q   <= '0;
      out_cnt_q  <= '0;
      id_idx_q   <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= '0;
      cont_q     <= 1'b0;
      underrun_q <= 1'b0;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      due_q      <= 1'b0;
      maddr_q    <= '0;
      due_addr_q <= '0;
      nxt_addr_q <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      sh_in_q    <= sh_in_d;
      out_sh_q   <= out_sh_d;
      out_cnt_q  <= out_cnt_d;
      id_idx_q   <= id_idx_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      cont_q     <= cont_d;
      underrun_q <= underrun_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
      due_q      <= due_d;
      maddr_q    <= maddr_d;
      due_addr_q <= due_addr_d;
      nxt_addr_q <= nxt_addr_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
    end
  end

  logic [23:0] sh_next, quad_next, fetch_addr;
  logic [7:0]  byte_v;
  logic        fetch_req, is_quad, quad_out;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    sh_in_d    = sh_in_q;
    out_sh_d   = out_sh_q;
    out_cnt_d  = out_cnt_q;
    id_idx_d   = id_idx_q;
    dq_o_d     = dq_o_q;
    dq_oe_d    = dq_oe_q;
    cont_d     = cont_q;
    underrun_d = underrun_q;
    req_d      = req_q;
    discard_d  = discard_q;
    due_d      = due_q;
    maddr_d    = maddr_q;
    due_addr_d = due_addr_q;
    nxt_addr_d = nxt_addr_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    fetch_req  = 1'b0;
    fetch_addr = nxt_addr_q;
    byte_v     = 8'h00;
    sh_next    = {sh_in_q, dq_s[0]};
    quad_next  = {sh_in_q[19:0], dq_s};
    is_quad    = (kind_q == RD_QUAD);
    quad_out   = (state_q == ST_DATA) && is_quad;

    // A completing fetch lands in the buffer unless its transaction was abandoned.
    if (req_q && mem_ack) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
      if (!discard_q) begin
        buf_d     = mem_data;
        buf_vld_d = 1'b1;
      end
    end

    if (cs_rise) begin
      state_d   = ST_IDLE;
      dq_oe_d   = 4'b0000;
      out_cnt_d = '0;
      buf_vld_d = 1'b0;
      due_d     = 1'b0;
      discard_d = req_d;
    end else if (!cs_n_s) begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            cnt_d     = '0;
            out_cnt_d = '0;
            id_idx_d  = '0;
            if (cont_q) begin
              state_d = ST_ADDR;
              kind_d  = RD_QUAD;
            end else begin
              state_d = ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            sh_in_d = sh_next[22:0];
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              case (sh_next[7:0])
                OP_READ:        begin state_d = ST_ADDR; kind_d = RD_SINGLE; end
                OP_FAST_READ:   begin state_d = ST_ADDR; kind_d = RD_FAST;   end
                OP_QUAD_READ:   begin state_d = ST_ADDR; kind_d = RD_QUAD;   end
                OP_READ_ID:     state_d = ST_ID;
                OP_READ_STATUS: state_d = ST_STATUS;
                default:        state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            sh_in_d = is_quad ? quad_next[22:0] : sh_next[22:0];
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == (is_quad ? 5'd5 : 5'd23)) begin
              cnt_d      = '0;
              fetch_req  = 1'b1;
              fetch_addr = is_quad ? quad_next : sh_next;
              nxt_addr_d = fetch_addr + 24'd1;
              case (kind_q)
                RD_SINGLE: state_d = ST_DATA;
                RD_FAST:   state_d = ST_DUMMY;
                default:   state_d = ST_MODE;
              endcase
            end
          end
        end
        ST_MODE: begin
          if (sck_rise) begin
            sh_in_d = quad_next[22:0];
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd1) begin
              cnt_d   = '0;
              cont_d  = (quad_next[5:4] == 2'b10);
              state_d = (QUAD_DUMMY == 0) ? ST_DATA : ST_DUMMY;
            end
          end
        end
        ST_DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == (is_quad ? QDUMMY_LAST : 5'd7)) begin
              cnt_d   = '0;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA, ST_ID, ST_STATUS: begin
          if (sck_fall) begin
            if (out_cnt_q == 3'd0) begin
              if (state_q == ST_DATA) begin
                // Each load consumes the prefetched byte and launches the next fetch.
                fetch_req  = 1'b1;
                fetch_addr = nxt_addr_q;
                nxt_addr_d = nxt_addr_q + 24'd1;
                buf_vld_d  = 1'b0;
                if (buf_vld_q) begin
                  byte_v = buf_q;
                end else begin
                  byte_v     = 8'hFF;
                  underrun_d = 1'b1;
                  discard_d  = req_d;
                end
              end else if (state_q == ST_ID) begin
                case (id_idx_q)
                  2'd0:    byte_v = JEDEC_ID[23:16];
                  2'd1:    byte_v = JEDEC_ID[15:8];
                  default: byte_v = JEDEC_ID[7:0];
                endcase
                id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
              end
              if (quad_out) begin
                dq_o_d    = byte_v[7:4];
                out_sh_d  = {byte_v[3:0], 4'b0000};
                out_cnt_d = 3'd1;
                dq_oe_d   = 4'b1111;
              end else begin
                dq_o_d    = {2'b00, byte_v[7], 1'b0};
                out_sh_d  = {byte_v[6:0], 1'b0};
                out_cnt_d = 3'd7;
                dq_oe_d   = 4'b0010;
              end
            end else begin
              out_cnt_d = out_cnt_q - 3'd1;
              if (quad_out) begin
                dq_o_d   = out_sh_q[7:4];
                out_sh_d = {out_sh_q[3:0], 4'b0000};
              end else begin
                dq_o_d   = {2'b00, out_sh_q[7], 1'b0};
                out_sh_d = {out_sh_q[6:0], 1'b0};
              end
            end
          end
        end
        default: dq_oe_d = 4'b0000;
      endcase
    end

    // A fetch waits here while an earlier (possibly discarded) one is still outstanding.
    if (fetch_req) begin
      due_d      = 1'b1;
      due_addr_d = fetch_addr;
    end
    if (due_d && !req_d) begin
      req_d   = 1'b1;
      maddr_d = due_addr_d;
      due_d   = 1'b0;
    end
  end

  assign dq_o     = dq_o_q;
  assign dq_oe    = dq_oe_q;
  assign mem_req  = req_q;
  assign mem_addr = maddr_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI mode-0 initiator tasks plus a latency-programmable memory.
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic [3:0]  dq_i = 4'b1100;
  logic [3:0]  dq_o, dq_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        underrun;

  int n_vec = 0;
  int n_bad = 0;

  spi_flash_responder #(.JEDEC_ID(24'hEF4016), .QUAD_DUMMY(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sck      (sck),
    .cs_n     (cs_n),
    .dq_i     (dq_i),
    .dq_o     (dq_o),
    .dq_oe    (dq_oe),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: answers each request after lat clocks with the XOR-fold of the address.
  int          lat = 2;
  int          wait_cnt = 0;
  logic [23:0] mlog [16];
  int          mlog_n = 0;
  logic [23:0] a_tmp;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        a_tmp    = mem_addr;
        mem_data = a_tmp[7:0] ^ a_tmp[15:8] ^ a_tmp[23:16];
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mlog_n < 16) begin
          mlog[mlog_n] = a_tmp;
          mlog_n++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  logic mon_en = 1'b0;
  logic [3:0] oe_seen = 4'b0000;
  always @(negedge clk) if (mon_en) oe_seen = oe_seen | dq_oe;

  task automatic spi_cycle(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    dq_i = din;
    #(HALF * 10);
    dout = dq_o;
    oe   = dq_oe;
    sck  = 1'b1;
    #(HALF * 10);
    sck  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] d, o;
    for (int i = 7; i >= 0; i--) spi_cycle({3'b110, b[i]}, d, o);
  endtask

  task automatic send_nib(input logic [3:0] n);
    logic [3:0] d, o;
    spi_cycle(n, d, o);
  endtask

  task automatic read_byte(output logic [7:0] b, output logic [3:0] oe);
    logic [3:0] d;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      spi_cycle(4'b1100, d, oe);
      b = {b[6:0], d[1]};
    end
  endtask

  task automatic read_qbyte(output logic [7:0] b, output logic [3:0] oe);
    logic [3:0] d;
    b = 8'h00;
    for (int i = 0; i < 2; i++) begin
      spi_cycle(4'b0000, d, oe);
      b = {b[3:0], d};
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    #(HALF * 10);
  endtask

  task automatic cs_end();
    #(HALF * 10);
    cs_n = 1'b1;
    #(HALF * 20);
  endtask

  task automatic quad_addr_mode(input logic [23:0] a, input logic [7:0] mode);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    send_nib(mode[7:4]);
    send_nib(mode[3:0]);
    for (int i = 0; i < 4; i++) send_nib(4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  b;
  logic [3:0]  oe;
  logic [7:0]  exp_id [4];
  logic [7:0]  exp_q  [3];

  initial begin
    exp_id = '{8'hEF, 8'h40, 8'h16, 8'hEF};
    exp_q  = '{8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 16; i++) mlog[i] = '1;
    repeat (5) @(negedge clk);
    chk("rst_dq_o", 32'(dq_o), 32'h0);
    chk("rst_dq_oe", 32'(dq_oe), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // JEDEC ID, wrapping back to the first byte
    oe_seen = 4'b0000;
    mon_en  = 1'b1;
    cs_start();
    send_byte(8'h9F);
    mon_en  = 1'b0;
    chk("id_oe_cmd", 32'(oe_seen), 32'h0);
    for (int i = 0; i < 4; i++) begin
      read_byte(b, oe);
      chk($sformatf("id_byte%0d", i), 32'(b), 32'(exp_id[i]));
    end
    chk("id_oe_data", 32'(oe), 32'h2);
    cs_end();
    chk("id_oe_after", 32'(dq_oe), 32'h0);

    // Single read with prefetch
    mlog_n = 0;
    cs_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    for (int i = 0; i < 4; i++) begin
      read_byte(b, oe);
      chk($sformatf("rd_byte%0d", i), 32'(b), 32'h10 + i);
    end
    cs_end();
    for (int i = 0; i < 5; i++) chk($sformatf("rd_addr%0d", i), 32'(mlog[i]), 32'h10 + i);

    // Quad read wrapping the top of memory, entering continuous mode
    cs_start();
    send_byte(8'hEB);
    quad_addr_mode(24'hFFFFFE, 8'h20);
    for (int i = 0; i < 3; i++) begin
      read_qbyte(b, oe);
      chk($sformatf("q_byte%0d", i), 32'(b), 32'(exp_q[i]));
    end
    chk("q_oe", 32'(oe), 32'hF);
    cs_end();

    // Continuous-mode transaction: no opcode, mode 0x00 leaves continuous mode
    cs_start();
    quad_addr_mode(24'h000100, 8'h00);
    read_qbyte(b, oe);
    chk("qc_byte0", 32'(b), 32'h01);
    read_qbyte(b, oe);
    chk("qc_byte1", 32'(b), 32'h00);
    cs_end();

    // Unknown opcode keeps the pads released
    oe_seen = 4'b0000;
    mon_en  = 1'b1;
    cs_start();
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h3C);
    cs_end();
    mon_en  = 1'b0;
    chk("ign_oe", 32'(oe_seen), 32'h0);

    cs_start();
    send_byte(8'h05);
    read_byte(b, oe);
    chk("st_byte", 32'(b), 32'h00);
    chk("st_oe", 32'(oe), 32'h2);
    cs_end();

    // Fast read with a slow memory -> underrun
    lat = 200;
    cs_start();
    send_byte(8'h0B);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    read_byte(b, oe);
    chk("ur_byte", 32'(b), 32'hFF);
    chk("ur_flag", 32'(underrun), 32'h1);
    cs_end();
    #3000;
    lat = 2;
    cs_start();
    send_byte(8'h05);
    read_byte(b, oe);
    cs_end();
    chk("ur_sticky", 32'(underrun), 32'h1);

    // Reset mid-DATA while a fetch is outstanding
    lat = 1000;
    cs_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h20);
    for (int i = 0; i < 4; i++) send_nib(4'b1100);
    @(negedge clk);
    chk("mr_req_before", 32'(mem_req), 32'h1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_oe", 32'(dq_oe), 32'h0);
    chk("mr_req", 32'(mem_req), 32'h0);
    chk("mr_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    cs_n    = 1'b1;
    repeat (20) @(negedge clk);
    chk("mr_underrun", 32'(underrun), 32'h0);
    lat = 2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
